// File: rtl/escritura_rtc_bus.sv
// rtl/escritura_rtc_bus.sv - writes snapshotted BCD seconds/minutes/hours to the RTC over the multiplexed AD bus
// Optional feature macro: RTC_TRANSFER_EN (adds a 4th transfer-command write after hours).
module escritura_rtc_bus #(
    parameter int          T_PULSE   = 5,
    parameter int          T_HOLD    = 2,
    parameter logic [7:0]  ADDR_SEG  = 8'h21,
    parameter logic [7:0]  ADDR_MIN  = 8'h22,
    parameter logic [7:0]  ADDR_HORA = 8'h23
`ifdef RTC_TRANSFER_EN
    ,
    parameter logic [7:0]  ADDR_CMD  = 8'hF2
`endif
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [7:0] dseg_i,
    input  logic [7:0] dmin_i,
    input  logic [7:0] dhora_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       cs_n_o,
    output logic       rd_n_o,
    output logic       wr_n_o,
    output logic       a_d_o,
    output logic [7:0] ad_out_o,
    output logic       ad_oe_o
);

    localparam int T_MAX = (T_PULSE > T_HOLD) ? T_PULSE : T_HOLD;
    localparam int CW    = $clog2(T_MAX + 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(T_HOLD - 1);
`ifdef RTC_TRANSFER_EN
    localparam logic [1:0] LAST_IDX = 2'd3;
`else
    localparam logic [1:0] LAST_IDX = 2'd2;
`endif

    typedef enum logic [2:0] {
        IDLE, ADDR_LO, ADDR_HI, DATA_LO, DATA_HI, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [7:0]      seg_q, min_q, hora_q;
    logic            load_snap;
    logic            busy_q, busy_d, done_q, done_d;
    logic            cs_n_q, cs_n_d, wr_n_q, wr_n_d, rd_n_q;
    logic            a_d_q, a_d_d, ad_oe_q, ad_oe_d;
    logic [7:0]      ad_out_q, ad_out_d;

    function automatic logic [7:0] addr_of(input logic [1:0] i);
        case (i)
            2'd0:    addr_of = ADDR_SEG;
            2'd1:    addr_of = ADDR_MIN;
            2'd2:    addr_of = ADDR_HORA;
`ifdef RTC_TRANSFER_EN
            default: addr_of = ADDR_CMD;
`else
            default: addr_of = 8'h00;
`endif
        endcase
    endfunction

    // The command write reuses its own address as the data byte.
    function automatic logic [7:0] data_of(input logic [1:0] i, input logic [7:0] s,
                                           input logic [7:0] m, input logic [7:0] h);
        case (i)
            2'd0:    data_of = s;
            2'd1:    data_of = m;
            2'd2:    data_of = h;
`ifdef RTC_TRANSFER_EN
            default: data_of = ADDR_CMD;
`else
            default: data_of = 8'h00;
`endif
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        load_snap = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cs_n_d    = cs_n_q;
        wr_n_d    = wr_n_q;
        a_d_d     = a_d_q;
        ad_oe_d   = ad_oe_q;
        ad_out_d  = ad_out_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    load_snap = 1'b1;
                    idx_d     = 2'd0;
                    busy_d    = 1'b1;
                    state_d   = ADDR_LO;
                    cnt_d     = PULSE_LD;
                    cs_n_d    = 1'b0;
                    wr_n_d    = 1'b0;
                    a_d_d     = 1'b0;
                    ad_oe_d   = 1'b1;
                    ad_out_d  = ADDR_SEG;
                end
            end
            ADDR_LO: begin
                if (cnt_q == '0) begin
                    state_d = ADDR_HI;
                    cnt_d   = HOLD_LD;
                    cs_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ADDR_HI: begin
                if (cnt_q == '0) begin
                    state_d  = DATA_LO;
                    cnt_d    = PULSE_LD;
                    cs_n_d   = 1'b0;
                    wr_n_d   = 1'b0;
                    a_d_d    = 1'b1;
                    ad_oe_d  = 1'b1;
                    ad_out_d = data_of(idx_q, seg_q, min_q, hora_q);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA_LO: begin
                if (cnt_q == '0) begin
                    state_d = DATA_HI;
                    cnt_d   = HOLD_LD;
                    cs_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA_HI: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ad_oe_d = 1'b0;
                    a_d_d   = 1'b0;
                end else begin
                    idx_d    = idx_q + 2'd1;
                    state_d  = ADDR_LO;
                    cnt_d    = PULSE_LD;
                    cs_n_d   = 1'b0;
                    wr_n_d   = 1'b0;
                    a_d_d    = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = addr_of(idx_q + 2'd1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            seg_q    <= 8'h00;
            min_q    <= 8'h00;
            hora_q   <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            a_d_q    <= 1'b0;
            ad_oe_q  <= 1'b0;
            ad_out_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            if (load_snap) begin
                seg_q  <= dseg_i;
                min_q  <= dmin_i;
                hora_q <= dhora_i;
            end
            busy_q   <= busy_d;
            done_q   <= done_d;
            cs_n_q   <= cs_n_d;
            wr_n_q   <= wr_n_d;
            rd_n_q   <= 1'b1;
            a_d_q    <= a_d_d;
            ad_oe_q  <= ad_oe_d;
            ad_out_q <= ad_out_d;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign cs_n_o   = cs_n_q;
    assign rd_n_o   = rd_n_q;
    assign wr_n_o   = wr_n_q;
    assign a_d_o    = a_d_q;
    assign ad_oe_o  = ad_oe_q;
    assign ad_out_o = ad_out_q;

endmodule

// File: tb/tb_escritura_rtc_bus.sv
// tb/tb_escritura_rtc_bus.sv - table-driven bench for escritura_rtc_bus (bus trace, snapshot, ignore-start, reset abort)
module tb_escritura_rtc_bus;

`ifdef RTC_TRANSFER_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif
    localparam int BYTE_CYC = 14;
    localparam int DONE_AT  = NB * BYTE_CYC;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] dseg, dmin, dhora;
    logic       busy, done, cs_n, rd_n, wr_n, a_d, ad_oe;
    logic [7:0] ad_out;

    escritura_rtc_bus dut (
        .clk_i(clk), .reset_i(reset), .start_i(start),
        .dseg_i(dseg), .dmin_i(dmin), .dhora_i(dhora),
        .busy_o(busy), .done_o(done), .cs_n_o(cs_n), .rd_n_o(rd_n),
        .wr_n_o(wr_n), .a_d_o(a_d), .ad_out_o(ad_out), .ad_oe_o(ad_oe)
    );

    always #5 clk = ~clk;

    // ctl = {cs_n, wr_n, a_d, ad_oe, busy, done}
    typedef struct {
        int         cyc;
        logic [5:0] ctl;
        logic [7:0] ad;
        logic       chk_ad;
    } vec_t;

    vec_t tbl[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic void add(input int c, input logic [5:0] ctl, input logic [7:0] ad,
                                input logic chk);
        vec_t v;
        v.cyc = c; v.ctl = ctl; v.ad = ad; v.chk_ad = chk;
        tbl.push_back(v);
    endfunction

    function automatic logic [5:0] ctl_now();
        return {cs_n, wr_n, a_d, ad_oe, busy, done};
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
    endtask

    logic [7:0] exp_addr [4];
    logic [7:0] exp_data [4];
    int         done_cnt, wr_cnt;
    logic       prev_wr_n;

    initial begin
        exp_addr[0] = 8'h21; exp_addr[1] = 8'h22; exp_addr[2] = 8'h23; exp_addr[3] = 8'hF2;
        exp_data[0] = 8'h45; exp_data[1] = 8'h30; exp_data[2] = 8'h12; exp_data[3] = 8'hF2;
        for (int b = 0; b < NB; b++) begin
            int base;
            base = b * BYTE_CYC;
            add(base + 0,  6'b000110, exp_addr[b], 1'b1);
            add(base + 4,  6'b000110, exp_addr[b], 1'b1);
            add(base + 5,  6'b110110, exp_addr[b], 1'b1);
            add(base + 6,  6'b110110, exp_addr[b], 1'b1);
            add(base + 7,  6'b001110, exp_data[b], 1'b1);
            add(base + 11, 6'b001110, exp_data[b], 1'b1);
            add(base + 12, 6'b111110, exp_data[b], 1'b1);
            add(base + 13, 6'b111110, exp_data[b], 1'b1);
        end
        add(DONE_AT,     6'b110001, 8'h00, 1'b0);
        add(DONE_AT + 1, 6'b110000, 8'h00, 1'b0);

        // Reset held with start asserted
        reset = 1'b0; start = 1'b1;
        dseg = 8'h45; dmin = 8'h30; dhora = 8'h12;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_ctl", 32'(ctl_now()), 32'(6'b110000));
            check("reset_ad", 32'({ad_out, rd_n}), 32'({8'h00, 1'b1}));
        end
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_ctl", 32'(ctl_now()), 32'(6'b110000));

        // Full burst; dseg edited after start, second start mid-burst
        pulse_start();
        done_cnt = 0; wr_cnt = 0; prev_wr_n = 1'b1;
        for (int s = 0; s <= DONE_AT + 6; s++) begin
            foreach (tbl[i]) begin
                if (tbl[i].cyc == s) begin
                    check($sformatf("burst_ctl@%0d", s), 32'(ctl_now()), 32'(tbl[i].ctl));
                    if (tbl[i].chk_ad)
                        check($sformatf("burst_ad@%0d", s), 32'(ad_out), 32'(tbl[i].ad));
                end
            end
            if (done) done_cnt++;
            if (prev_wr_n && !wr_n && a_d) wr_cnt++;
            prev_wr_n = wr_n;
            if (s == 0)  begin start = 1'b0; dseg = 8'h59; end
            if (s == 10) start = 1'b1;
            if (s == 11) start = 1'b0;
            @(negedge clk);
        end
        check("done_count", 32'(done_cnt), 32'd1);
        check("write_count", 32'(wr_cnt), 32'(NB));
        check("rd_n_const", 32'(rd_n), 32'd1);

        // Reset during minutes DATA_LO aborts the burst
        dseg = 8'h07; dmin = 8'h08; dhora = 8'h09;
        pulse_start();
        start = 1'b0;
        for (int s = 0; s < 22; s++) @(negedge clk);
        check("pre_abort_ad", 32'({cs_n, a_d, ad_out}), 32'({1'b0, 1'b1, 8'h08}));
        reset = 1'b0;
        @(negedge clk);
        check("abort_ctl", 32'({cs_n, wr_n, ad_oe, busy, done}), 32'(5'b11000));
        reset = 1'b1;
        done_cnt = 0;
        for (int s = 0; s < 60; s++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_idle", 32'(ctl_now()), 32'(6'b110000));

        // New burst restarts from seconds with fresh snapshot
        dseg = 8'h33;
        pulse_start();
        start = 1'b0;
        check("restart_addr", 32'({ctl_now(), ad_out}), 32'({6'b000110, 8'h21}));
        for (int s = 0; s < 7; s++) @(negedge clk);
        check("restart_data", 32'({ctl_now(), ad_out}), 32'({6'b001110, 8'h33}));
        done_cnt = 0;
        for (int s = 7; s < DONE_AT + 4; s++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("restart_done", 32'(done_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
